tdm_mux: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer with manual and automatic time-division scan modes. Successor to the team's fixed 4:1 1-bit combinational mux, for wider data paths that need a registered output, a valid flag and a round-robin scan with programmable dwell. It sits between parallel sample sources and a single downstream serial consumer, such as a display driver, UART framer or logger.

---
 rtl/tdm_mux_pkg.sv | 30 +++
 rtl/tdm_mux_sel.sv | 37 +++
 rtl/tdm_mux.sv | 170 +++++++++++++++++
 tb/tb_tdm_mux.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_mux_pkg
// Description : Shared types and helpers for the tdm_mux block.
//               - state_t     : operating state (IDLE / MANUAL / SCAN)
//               - MODE_MANUAL : mode input value selecting manual select
//               - MODE_SCAN   : mode input value selecting auto-scan
//               - clog2_min1  : ceil(log2(v)) clamped to a minimum of 1
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A counter that only ever needs to hold 0 still needs one bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_mux_sel.sv
`default_nettype none
// ============================================================================
// Module      : tdm_mux_sel
// Description : Purely combinational CHANNELS:1 selector of WIDTH-bit words
//               with an out-of-range flag for indices >= CHANNELS.
// Ports       : x_i   - flattened inputs, channel k at [k*WIDTH +: WIDTH]
//               idx_i - channel index
//               y_o   - selected word (0 when out of range)
//               oor_o - high when idx_i does not name a channel
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_mux_sel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] x_i,
    input  logic [SEL_W-1:0]          idx_i,
    output logic [WIDTH-1:0]          y_o,
    output logic                      oor_o
);

    // Compare against every legal index so a non-power-of-two channel count
    // never indexes past the end of x_i.
    always_comb begin
        y_o   = '0;
        oor_o = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx_i == SEL_W'(k)) begin
                y_o   = x_i[k*WIDTH +: WIDTH];
                oor_o = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_mux.sv
`default_nettype none
// ============================================================================
// Module      : tdm_mux
// Description : Registered N-channel, W-bit multiplexer with manual select
//               and round-robin auto-scan with programmable dwell.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous active-high reset
//               x       - flattened inputs, channel k at [k*WIDTH +: WIDTH]
//               en      - enable (low = idle)
//               mode    - 0 manual select, 1 auto-scan
//               sel     - channel index for manual mode
//               ch_mask - per-channel scan enable (TDM_MUX_MASK_EN only)
//               z       - registered selected data
//               z_ch    - channel index z came from
//               z_valid - z/z_ch hold a valid sample
//               wrap    - pulse on the final scan cycle of channel CHANNELS-1
// Build macro : TDM_MUX_MASK_EN adds ch_mask; masked channels are skipped
//               in scan mode with a one-cycle bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_mux
    import tdm_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] x,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
`ifdef TDM_MUX_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          z,
    output logic [SEL_W-1:0]          z_ch,
    output logic                      z_valid,
    output logic                      wrap
);

    localparam int                DCNT_W     = clog2_min1(DWELL);
    localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(CHANNELS - 1);
    localparam logic [DCNT_W-1:0] LAST_DWELL = DCNT_W'(DWELL - 1);

    state_t              state;
    logic [WIDTH-1:0]    z_q,       z_d;
    logic [SEL_W-1:0]    z_ch_q,    z_ch_d;
    logic                z_valid_q, z_valid_d;
    logic                wrap_q,    wrap_d;
    logic [SEL_W-1:0]    ch_ptr_q,  ch_ptr_d;
    logic [DCNT_W-1:0]   dwell_q,   dwell_d;

    logic [SEL_W-1:0]    w_idx;
    logic [WIDTH-1:0]    w_data;
    logic                w_oor;
    logic                w_masked;
    logic                w_last_ch;
    logic [SEL_W-1:0]    w_ptr_next;

    // The state is a pure decode of the control inputs: the block reacts to
    // en/mode in the same cycle they are presented.
    always_comb begin
        state = IDLE;
        if (en) begin
            state = (mode == MODE_SCAN) ? SCAN : MANUAL;
        end
    end

    // One selector serves both modes.
    assign w_idx = (state == SCAN) ? ch_ptr_q : sel;

    tdm_mux_sel #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_sel (
        .x_i   (x),
        .idx_i (w_idx),
        .y_o   (w_data),
        .oor_o (w_oor)
    );

`ifdef TDM_MUX_MASK_EN
    always_comb begin
        w_masked = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_ptr_q == SEL_W'(k)) begin
                w_masked = ~ch_mask[k];
            end
        end
    end
`else
    assign w_masked = 1'b0;
`endif

    assign w_last_ch  = (ch_ptr_q == LAST_CH);
    assign w_ptr_next = w_last_ch ? '0 : ch_ptr_q + SEL_W'(1);

    always_comb begin
        z_d       = z_q;
        z_ch_d    = z_ch_q;
        z_valid_d = 1'b0;
        wrap_d    = 1'b0;
        // Pointers fall back to zero outside SCAN so every scan entry starts
        // at channel 0 with a full dwell.
        ch_ptr_d  = '0;
        dwell_d   = '0;
        case (state)
            IDLE: begin
            end
            MANUAL: begin
                z_ch_d = sel;
                if (w_oor) begin
                    z_d = '0;
                end else begin
                    z_d       = w_data;
                    z_valid_d = 1'b1;
                end
            end
            SCAN: begin
                if (w_masked) begin
                    // Bubble: hold z/z_ch and skip the channel without dwell.
                    ch_ptr_d = w_ptr_next;
                    wrap_d   = w_last_ch;
                end else begin
                    z_d       = w_data;
                    z_ch_d    = ch_ptr_q;
                    z_valid_d = 1'b1;
                    if (dwell_q == LAST_DWELL) begin
                        ch_ptr_d = w_ptr_next;
                        wrap_d   = w_last_ch;
                    end else begin
                        ch_ptr_d = ch_ptr_q;
                        dwell_d  = dwell_q + DCNT_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q       <= '0;
            z_ch_q    <= '0;
            z_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
            ch_ptr_q  <= '0;
            dwell_q   <= '0;
        end else begin
            z_q       <= z_d;
            z_ch_q    <= z_ch_d;
            z_valid_q <= z_valid_d;
            wrap_q    <= wrap_d;
            ch_ptr_q  <= ch_ptr_d;
            dwell_q   <= dwell_d;
        end
    end

    assign z       = z_q;
    assign z_ch    = z_ch_q;
    assign z_valid = z_valid_q;
    assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_mux
// Description : Self-checking bench for tdm_mux (WIDTH=8, CHANNELS=4,
//               DWELL=2) plus a CHANNELS=3 instance for out-of-range select.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_mux;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int D  = 2;
    localparam int SW = 2;
    localparam logic [C*W-1:0] X0 = {8'h44, 8'h33, 8'h22, 8'h11};

    logic           clk = 1'b0;
    logic           rst;
    logic [C*W-1:0] x;
    logic           en, mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   z;
    logic [SW-1:0]  z_ch;
    logic           z_valid, wrap;

    logic [3*W-1:0] x3;
    logic           en3, mode3;
    logic [1:0]     sel3;
    logic [W-1:0]   z3;
    logic [1:0]     z_ch3;
    logic           z_valid3, wrap3;

`ifdef TDM_MUX_MASK_EN
    logic [C-1:0]   ch_mask;
    logic [2:0]     ch_mask3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0]  m_z;
    logic [SW-1:0] m_zch;
    logic          m_valid, m_wrap;
    int            m_t;   // cycles since entering scan

    tdm_mux #(.WIDTH(W), .CHANNELS(C), .DWELL(D)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
`ifdef TDM_MUX_MASK_EN
        .ch_mask (ch_mask),
`endif
        .z       (z),
        .z_ch    (z_ch),
        .z_valid (z_valid),
        .wrap    (wrap)
    );

    tdm_mux #(.WIDTH(W), .CHANNELS(3), .DWELL(D)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .x       (x3),
        .en      (en3),
        .mode    (mode3),
        .sel     (sel3),
`ifdef TDM_MUX_MASK_EN
        .ch_mask (ch_mask3),
`endif
        .z       (z3),
        .z_ch    (z_ch3),
        .z_valid (z_valid3),
        .wrap    (wrap3)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: scan position follows directly from the count of scan cycles.
    task automatic model_step();
        int ch;
        if (!en) begin
            m_valid = 1'b0;
            m_wrap  = 1'b0;
            m_t     = 0;
        end else if (!mode) begin
            m_t    = 0;
            m_wrap = 1'b0;
            m_zch  = sel;
            m_z    = x[int'(sel)*W +: W];
            m_valid = 1'b1;
        end else begin
            ch      = (m_t / D) % C;
            m_z     = x[ch*W +: W];
            m_zch   = SW'(ch);
            m_valid = 1'b1;
            m_wrap  = ((m_t % (C*D)) == (C*D - 1));
            m_t++;
        end
    endtask

    task automatic test_reset();
        en = 1'b1; mode = 1'b1; x = X0;
        cyc(); cyc(); cyc();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (z !== 8'h00 || z_valid !== 1'b0 || wrap !== 1'b0 || z_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_async: z=%h ch=%0d v=%b wrap=%b, want 00 0 0 0", z, z_ch, z_valid, wrap);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cyc();
        n_tests++;
        if (z !== 8'h11 || z_ch !== 2'd0 || z_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: z=%h ch=%0d v=%b, want 11 0 1", z, z_ch, z_valid);
        end
    endtask

    task automatic test_manual();
        en = 1'b1; mode = 1'b0; sel = 2'd2; x = X0;
        cyc();
        n_tests++;
        if (z !== 8'h33 || z_ch !== 2'd2 || z_valid !== 1'b1 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL manual_sel2: z=%h ch=%0d v=%b w=%b, want 33 2 1 0", z, z_ch, z_valid, wrap);
        end
        sel = 2'd3;
        cyc();
        n_tests++;
        if (z !== 8'h44 || z_ch !== 2'd3 || z_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL manual_sel3: z=%h ch=%0d v=%b, want 44 3 1", z, z_ch, z_valid);
        end
    endtask

    task automatic test_scan();
        logic [W-1:0] exp_z [10] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33,
                                      8'h33, 8'h44, 8'h44, 8'h11, 8'h11};
        en = 1'b0; x = X0;
        cyc();
        en = 1'b1; mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_tests++;
            if (z !== exp_z[i] || z_ch !== SW'((i / 2) % 4) || z_valid !== 1'b1 ||
                wrap !== (i == 7)) begin
                n_fail++;
                $display("FAIL scan_cycle%0d: z=%h ch=%0d v=%b w=%b, want %h %0d 1 %b",
                         i + 1, z, z_ch, z_valid, wrap, exp_z[i], (i / 2) % 4, (i == 7));
            end
        end
    endtask

    task automatic test_interrupt();
        logic [W-1:0] exp_z [3] = '{8'h11, 8'h11, 8'h22};
        en = 1'b0; x = X0;
        cyc();
        en = 1'b1; mode = 1'b1;
        cyc(); cyc(); cyc();
        n_tests++;
        if (z !== 8'h22) begin
            n_fail++;
            $display("FAIL intr_before: z=%h, want 22", z);
        end
        mode = 1'b0; sel = 2'd0;
        cyc();
        n_tests++;
        if (z !== 8'h11 || z_ch !== 2'd0 || z_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL intr_manual: z=%h ch=%0d v=%b, want 11 0 1", z, z_ch, z_valid);
        end
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if (z !== exp_z[i] || z_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL intr_rescan%0d: z=%h v=%b, want %h 1", i, z, z_valid, exp_z[i]);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_tests++;
            if (z !== 8'h22 || z_valid !== 1'b0 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL intr_idle%0d: z=%h v=%b w=%b, want 22 0 0", i, z, z_valid, wrap);
            end
        end
    endtask

    task automatic test_out_of_range();
        x3 = 24'h332211; en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd2;
        cyc();
        n_tests++;
        if (z3 !== 8'h33 || z_valid3 !== 1'b1 || z_ch3 !== 2'd2) begin
            n_fail++;
            $display("FAIL oor_inrange: z=%h v=%b ch=%0d, want 33 1 2", z3, z_valid3, z_ch3);
        end
        sel3 = 2'd3;
        cyc();
        n_tests++;
        if (z3 !== 8'h00 || z_valid3 !== 1'b0 || z_ch3 !== 2'd3) begin
            n_fail++;
            $display("FAIL oor_sel3: z=%h v=%b ch=%0d, want 00 0 3", z3, z_valid3, z_ch3);
        end
        en3 = 1'b0;
    endtask

`ifdef TDM_MUX_MASK_EN
    task automatic test_mask();
        logic         exp_v [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] exp_z [6];
        en = 1'b1; mode = 1'b0; sel = 2'd0; x = X0;
        cyc();                      // leaves z = 11 as the held value
        exp_z = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h44, 8'h44};
        ch_mask = 4'b1010; mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_tests++;
            if (z_valid !== exp_v[i] || z !== exp_z[i] || wrap !== (i == 5)) begin
                n_fail++;
                $display("FAIL mask_cycle%0d: z=%h v=%b w=%b, want %h %b %b",
                         i + 1, z, z_valid, wrap, exp_z[i], exp_v[i], (i == 5));
            end
        end
        ch_mask = '1;
    endtask
`endif

    task automatic test_random();
        en = 1'b1; mode = 1'b0; sel = 2'd0; x = $urandom;
        model_step();
        cyc();
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 7) != 0);
            mode = ($urandom_range(0, 3) != 0);
            sel  = SW'($urandom_range(0, 3));
            x    = $urandom;
            model_step();
            cyc();
            n_tests++;
            if (z !== m_z || z_ch !== m_zch || z_valid !== m_valid || wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL random%0d: z=%h ch=%0d v=%b w=%b, want %h %0d %b %b",
                         i, z, z_ch, z_valid, wrap, m_z, m_zch, m_valid, m_wrap);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; x = X0;
        en3 = 1'b0; mode3 = 1'b0; sel3 = '0; x3 = '0;
        m_z = '0; m_zch = '0; m_valid = 1'b0; m_wrap = 1'b0; m_t = 0;
`ifdef TDM_MUX_MASK_EN
        ch_mask = '1; ch_mask3 = '1;
`endif
        cyc();
        n_tests++;
        if (z !== 8'h00 || z_ch !== 2'd0 || z_valid !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: z=%h ch=%0d v=%b w=%b, want 00 0 0 0", z, z_ch, z_valid, wrap);
        end
        rst = 1'b0;
        test_reset();
        test_manual();
        test_scan();
        test_interrupt();
        test_out_of_range();
`ifdef TDM_MUX_MASK_EN
        test_mask();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
